// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared definitions for the load/store memory responder and the core's
// store path.
//   mem_state_t : responder FSM encoding (IDLE, BUSY, RESP)
//   MEM_BASE    : default byte address of storage word 0
//   wmask_t     : 4-bit byte-lane enable, bit i enables data[8*i +: 8]
//   lane_merge  : applies a byte-lane mask to combine old and new words
package ysyx_24100005_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam logic [31:0] MEM_BASE = 32'h8000_0000;

   localparam int WMASK_LANES = 4;

   typedef logic [WMASK_LANES-1:0] wmask_t;

   // Replace only the byte lanes whose mask bit is set; other lanes keep
   // the old word's contents.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input wmask_t      mask);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < WMASK_LANES; i++) begin
         if (mask[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/ysyx_24100005_sram_array.sv
// Byte-masked synchronous single-port storage, DEPTH words of 32 bits.
// Ports:
//   clk   : rising-edge clock
//   en    : perform an access at this edge
//   we    : 1 = masked write, 0 = read
//   idx   : word index
//   wdata : write data, lane-aligned
//   wmask : byte-lane enables for writes
//   rdata : registered read data, updated only by read accesses
// Contents are never cleared; DEPTH must be a power of two and at least 2.
module ysyx_24100005_sram_array
   import ysyx_24100005_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   localparam int IDXW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [IDXW-1:0] idx,
   input  logic [31:0]     wdata,
   input  wmask_t          wmask,
   output logic [31:0]     rdata
);

   logic [31:0] mem [DEPTH];

   // Single access per enabled edge. A read returns the word as it was
   // before the edge; writes merge only the enabled byte lanes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= lane_merge(mem[idx], wdata, wmask);
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/ysyx_24100005_mem_responder.sv
// Memory-side responder for the core's load/store port.
// One request at a time is accepted over req_valid/req_ready, the access is
// committed LATENCY edges after acceptance, and the result is presented on
// resp_valid/resp_ready until the core takes it.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake
//   req_wen, req_addr         : store flag, byte address (bits [1:0] ignored)
//   req_wdata, req_wmask      : lane-aligned store data and byte enables
//   resp_valid / resp_ready   : response handshake
//   resp_rdata                : load data, 0 for stores and errors
//   resp_err                  : address outside [BASE, BASE + 4*DEPTH)
module ysyx_24100005_mem_responder
   import ysyx_24100005_mem_pkg::*;
#(
   parameter int          DEPTH   = 1024,
   parameter logic [31:0] BASE    = MEM_BASE,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  wmask_t      req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDXW     = $clog2(DEPTH);
   localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
   localparam logic [3:0]  CNT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

   mem_state_t  state;
   mem_state_t  state_next;
   logic [3:0]  cnt;
   logic        req_fire;
   logic        commit;
   logic        resp_fire;

   logic        lat_wen;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   wmask_t      lat_wmask;

   logic        c_wen;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   wmask_t      c_wmask;
   logic [32:0] offset;
   logic        in_range;
   logic        rd_sel;
   logic        err_q;
   logic [31:0] sram_rdata;
   logic        unused_offset_bits;

   // Operands for the commit. With zero latency the access happens at the
   // acceptance edge, so the live request is used instead of the latch.
   always_comb begin
      c_wen   = lat_wen;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_wmask = lat_wmask;
      if (LATENCY == 0) begin
         c_wen   = req_wen;
         c_addr  = req_addr;
         c_wdata = req_wdata;
         c_wmask = req_wmask;
      end
   end

   // Range check done in 33 bits so addresses near the top of the 32-bit
   // space cannot wrap back into the window.
   assign offset             = {1'b0, c_addr} - {1'b0, BASE};
   assign in_range           = (c_addr >= BASE) && (offset < SPAN);
   assign unused_offset_bits = ^{offset[32:IDXW+2], offset[1:0]};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. Reset suppresses both acceptance and
   // commit in the same cycle, so a store caught by reset never writes.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      req_fire   = 1'b0;
      commit     = 1'b0;
      resp_fire  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            req_fire  = req_valid && !rst;
            if (req_fire) begin
               if (LATENCY == 0) begin
                  commit     = 1'b1;
                  state_next = RESP;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               commit     = !rst;
               state_next = RESP;
            end
         end
         RESP: begin
            resp_fire = resp_ready;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign resp_valid = (state == RESP);

   // Request latch; only meaningful while a transaction is outstanding.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         lat_wen   <= req_wen;
         lat_addr  <= req_addr;
         lat_wdata <= req_wdata;
         lat_wmask <= req_wmask;
      end
   end

   // Latency counter and response flags. rd_sel marks that the storage read
   // register holds this response's data; it and err_q are cleared once the
   // response is taken so the outputs return to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= 4'd0;
         rd_sel <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (req_fire) begin
            cnt <= CNT_LOAD;
         end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            rd_sel <= !c_wen && in_range;
            err_q  <= !in_range;
         end else if (resp_fire) begin
            rd_sel <= 1'b0;
            err_q  <= 1'b0;
         end
      end
   end

   ysyx_24100005_sram_array #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .en    (commit && in_range),
      .we    (c_wen),
      .idx   (offset[IDXW+1:2]),
      .wdata (c_wdata),
      .wmask (c_wmask),
      .rdata (sram_rdata)
   );

   assign resp_rdata = rd_sel ? sram_rdata : 32'd0;
   assign resp_err   = err_q;

endmodule
